// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick helper for the 4-way arbiter.
// The timeout feature is enabled with `define ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan from p upward (mod NUM_REQ).
    // Iterating downward lets the closest requester overwrite the others.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] p);
        pick_t            res;
        logic [IDX_W-1:0] c;
        res.found = 1'b0;
        res.idx   = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = p + IDX_W'(i);
            if (r[c]) begin
                res.found = 1'b1;
                res.idx   = c;
            end else begin
                res.found = res.found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The requester side uses modport master; the arbiter uses modport slave.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout;

    modport master (output req, input grant, input grant_idx, input grant_valid, input timeout);
    modport slave  (input req, output grant, output grant_idx, output grant_valid, output timeout);
endinterface

// File: rtl/arb_idx_decode.sv
// 2->4 one-hot decode of the registered owner index.
// The output is forced to zero while there is no owner.
module arb_idx_decode
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               valid,
    output logic [NUM_REQ-1:0] onehot
);

    assign onehot = valid ? (NUM_REQ'(1) << idx) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/rr_arbiter_4.sv
// 4-requester round-robin arbiter that holds a grant until its owner releases.
// Optional forced revocation after MAX_HOLD cycles is enabled by `define ARB_TIMEOUT_EN.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter_4_if.slave   bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD >= (1 << HOLD_W)) begin : g_bad_param
        $error("rr_arbiter_4: MAX_HOLD out of range for HOLD_W");
    end

    state_e           state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] idx_r;
    logic             valid_r;

    pick_t            pick_idle_s;
    pick_t            pick_next_s;
    logic             owner_req_s;
    logic [IDX_W-1:0] next_ptr_s;

    // Winner candidates: fresh search from ptr, and a search that skips the current owner.
    always_comb begin
        next_ptr_s  = idx_r + IDX_W'(1);
        owner_req_s = bus.req[idx_r];
        pick_idle_s = rr_pick(bus.req, ptr_r);
        pick_next_s = rr_pick(bus.req & ~(NUM_REQ'(1) << idx_r), next_ptr_s);
    end

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              timeout_r;
    logic              hold_exp_s;

    assign hold_exp_s  = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    assign bus.timeout = timeout_r;

    // Arbitration FSM, with the hold counter that forces revocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= IDX_W'(0);
            idx_r      <= IDX_W'(0);
            valid_r    <= 1'b0;
            hold_cnt_r <= HOLD_W'(0);
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_idle_s.found) begin
                        idx_r      <= pick_idle_s.idx;
                        valid_r    <= 1'b1;
                        hold_cnt_r <= HOLD_W'(0);
                        state_r    <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (!owner_req_s) begin
                        ptr_r      <= next_ptr_s;
                        hold_cnt_r <= HOLD_W'(0);
                        if (pick_next_s.found) begin
                            idx_r <= pick_next_s.idx;
                        end else begin
                            valid_r <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else if (hold_exp_s) begin
                        // Revoke only when someone else is waiting.
                        hold_cnt_r <= HOLD_W'(0);
                        if (pick_next_s.found) begin
                            ptr_r     <= next_ptr_s;
                            idx_r     <= pick_next_s.idx;
                            timeout_r <= 1'b1;
                        end else begin
                            timeout_r <= 1'b0;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
`else
    assign bus.timeout = 1'b0;

    // Arbitration FSM; the owner keeps the grant for as long as it requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= IDX_W'(0);
            idx_r   <= IDX_W'(0);
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_idle_s.found) begin
                        idx_r   <= pick_idle_s.idx;
                        valid_r <= 1'b1;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (!owner_req_s) begin
                        ptr_r <= next_ptr_s;
                        if (pick_next_s.found) begin
                            idx_r <= pick_next_s.idx;
                        end else begin
                            valid_r <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign bus.grant_idx   = idx_r;
    assign bus.grant_valid = valid_r;

    arb_idx_decode u_decode (
        .idx    (idx_r),
        .valid  (valid_r),
        .onehot (bus.grant)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, rotation, wrap, release, hold limit, mid-grant reset.
// Hold-limit steps follow `define ARB_TIMEOUT_EN; the DUT is built with MAX_HOLD=4.
module tb_rr_arbiter_4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_arbiter_4_if arb_if ();

    rr_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic v);
        chk({tag, "_grant"}, {4'b0000, arb_if.grant}, {4'b0000, g});
        chk({tag, "_idx"}, {6'b000000, arb_if.grant_idx}, {6'b000000, idx});
        chk({tag, "_valid"}, {7'b0000000, arb_if.grant_valid}, {7'b0000000, v});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with every requester active
        rst        = 1'b1;
        arb_if.req = 4'b1111;
        tick();
        tick();
        chk_grant("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset_timeout", {7'b0000000, arb_if.timeout}, 8'h00);
        rst = 1'b0;
        tick();
        chk_grant("first", 4'b0001, 2'd0, 1'b1);

        // Back-to-back rotation without idle cycles
        arb_if.req = 4'b1110;
        tick();
        chk_grant("rot1", 4'b0010, 2'd1, 1'b1);
        arb_if.req = 4'b1101;
        tick();
        chk_grant("rot2", 4'b0100, 2'd2, 1'b1);
        arb_if.req = 4'b1011;
        tick();
        chk_grant("rot3", 4'b1000, 2'd3, 1'b1);
        arb_if.req = 4'b0111;
        tick();
        chk_grant("rot4", 4'b0001, 2'd0, 1'b1);

        // Pointer wrap from idx 3, then from idx 0
        arb_if.req = 4'b1000;
        tick();
        chk_grant("wrap_own3", 4'b1000, 2'd3, 1'b1);
        arb_if.req = 4'b0011;
        tick();
        chk_grant("wrap_3to0", 4'b0001, 2'd0, 1'b1);
        arb_if.req = 4'b0010;
        tick();
        chk_grant("wrap_0to1", 4'b0010, 2'd1, 1'b1);
        arb_if.req = 4'b0000;
        tick();
        chk_grant("release_idle", 4'b0000, 2'd1, 1'b0);

        // Single request, hold, drop
        arb_if.req = 4'b0100;
        tick();
        chk_grant("single", 4'b0100, 2'd2, 1'b1);
        tick();
        chk_grant("single_hold", 4'b0100, 2'd2, 1'b1);
        arb_if.req = 4'b0000;
        tick();
        chk_grant("single_drop", 4'b0000, 2'd2, 1'b0);

        // Hold limit: pointer is now 3, so requester 0 wins first
        arb_if.req = 4'b0011;
        tick();
        chk_grant("hold_start", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grant("hold_keep", 4'b0001, 2'd0, 1'b1);
            chk("hold_keep_to", {7'b0000000, arb_if.timeout}, 8'h00);
        end
        tick();
        chk_grant("to_revoke", 4'b0010, 2'd1, 1'b1);
        chk("to_pulse", {7'b0000000, arb_if.timeout}, 8'h01);
        tick();
        chk_grant("to_after", 4'b0010, 2'd1, 1'b1);
        chk("to_pulse_end", {7'b0000000, arb_if.timeout}, 8'h00);
        arb_if.req = 4'b0001;
        tick();
        chk_grant("alone_start", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_grant("alone_keep", 4'b0001, 2'd0, 1'b1);
            chk("alone_to", {7'b0000000, arb_if.timeout}, 8'h00);
        end
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_grant("unbounded", 4'b0001, 2'd0, 1'b1);
            chk("unbounded_to", {7'b0000000, arb_if.timeout}, 8'h00);
        end
`endif
        arb_if.req = 4'b0000;
        tick();
        chk_grant("hold_drop", 4'b0000, 2'd0, 1'b0);

        // Reset in the middle of a grant brings the pointer back to 0
        arb_if.req = 4'b0100;
        tick();
        chk_grant("mid_own2", 4'b0100, 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        chk_grant("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst        = 1'b0;
        arb_if.req = 4'b0101;
        tick();
        chk_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
